ext_obi_rr_arbiter: RTL and testbench



---
 rtl/ext_arb_pkg.sv | 9 +
 rtl/obi_pkg.sv | 18 +
 rtl/ext_arb_idx_fifo.sv | 70 +++++++
 rtl/ext_obi_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_ext_obi_rr_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_arb_pkg.sv
// rtl/ext_arb_pkg.sv - shared constants and index type for the external OBI arbiter.
package ext_arb_pkg;

    localparam int unsigned EXT_ARB_NMASTER   = 4;
    localparam int unsigned EXT_ARB_DEBUG_IDX = 2;

    typedef logic [$clog2(EXT_ARB_NMASTER)-1:0] arb_idx_t;

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response bus types.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/ext_arb_idx_fifo.sv
// rtl/ext_arb_idx_fifo.sv - in-order FIFO of requester indices awaiting their response.
module ext_arb_idx_fifo
    import ext_arb_pkg::*;
#(
    parameter type         T     = arb_idx_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  T                               data_i,
    input  logic                           pop_i,
    output logic                           full_o,
    output logic                           empty_o,
    output T                               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    // Explicit wrap keeps DEPTH=1 (1-bit pointer, one slot) correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ext_obi_rr_arbiter.sv
// rtl/ext_obi_rr_arbiter.sv - N-to-1 OBI arbiter: round-robin with optional fixed high
// priority, address-phase locking and in-order response routing.
module ext_obi_rr_arbiter
    import ext_arb_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned NMASTER         = EXT_ARB_NMASTER,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned HIPRIO_EN       = 1,
    parameter int unsigned HIPRIO_IDX      = EXT_ARB_DEBUG_IDX
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  obi_req_t  [NMASTER-1:0]                master_req_i,
    output obi_resp_t [NMASTER-1:0]                master_resp_o,
    output obi_req_t                               slave_req_o,
    input  obi_resp_t                              slave_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned IDX_W = $clog2(NMASTER);
    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  LOCKED = 1'b1;

    typedef logic [IDX_W-1:0] idx_t;

    logic [0:0]  state_q, state_d;
    idx_t        locked_idx_q, locked_idx_d;
    idx_t        rr_ptr_q, rr_ptr_d;
    logic        err_q, err_d;

    idx_t        sel;
    logic        sel_valid;
    logic        grant;
    logic        pop;
    logic        fifo_full, fifo_empty;
    idx_t        fifo_head;
    int unsigned cand;

    // A locked address phase wins over everything; otherwise a full FIFO blocks issue.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = 0;
        if (state_q == LOCKED) begin
            sel       = locked_idx_q;
            sel_valid = master_req_i[locked_idx_q].req;
        end else if (!fifo_full) begin
            if (HIPRIO_EN != 0 && master_req_i[HIPRIO_IDX].req) begin
                sel       = idx_t'(HIPRIO_IDX);
                sel_valid = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NMASTER; k++) begin
                    cand = int'(rr_ptr_q) + k;
                    if (cand >= NMASTER) begin
                        cand = cand - NMASTER;
                    end
                    if (!sel_valid && master_req_i[idx_t'(cand)].req) begin
                        sel       = idx_t'(cand);
                        sel_valid = 1'b1;
                    end
                end
            end
        end
    end

    assign grant = sel_valid && slave_resp_i.gnt;
    assign pop   = slave_resp_i.rvalid && !fifo_empty;

    always_comb begin
        slave_req_o   = '0;
        master_resp_o = '0;
        if (sel_valid) begin
            slave_req_o = master_req_i[sel];
        end
        if (grant) begin
            master_resp_o[sel].gnt = 1'b1;
        end
        if (pop) begin
            master_resp_o[fifo_head].rvalid = 1'b1;
            master_resp_o[fifo_head].rdata  = slave_resp_i.rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        err_d        = err_q;
        if (grant) begin
            state_d  = IDLE;
            rr_ptr_d = (sel == idx_t'(NMASTER - 1)) ? '0 : sel + idx_t'(1);
        end else if (sel_valid) begin
            state_d      = LOCKED;
            locked_idx_d = sel;
        end else begin
            // Also covers a locked requester withdrawing its request before grant.
            state_d = IDLE;
        end
        if (slave_resp_i.rvalid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_idx_q <= locked_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
        end
    end

    assign err_o = err_q;

    ext_arb_idx_fifo #(
        .T     (idx_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_ext_obi_rr_arbiter.sv
// tb/tb_ext_obi_rr_arbiter.sv - bench for ext_obi_rr_arbiter with a queue-based reference model.
module tb_ext_obi_rr_arbiter;
    import obi_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 2;
    localparam int HPI  = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic                clk = 1'b0;
    logic                rst;
    obi_req_t  [N-1:0]   mreq;
    obi_resp_t [N-1:0]   mresp;
    obi_req_t            sreq;
    obi_resp_t           sresp;
    logic [CW-1:0]       outst;
    logic                err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int       m_fifo[$];
    int       m_rr;
    bit       m_lock;
    int       m_lidx;
    bit       m_err;
    bit [N-1:0] m_last_gnt;
    bit       p_valid;
    int       p_sel;

    always #5 clk = ~clk;

    ext_obi_rr_arbiter #(
        .NMASTER         (N),
        .MAX_OUTSTANDING (MAXO),
        .HIPRIO_EN       (1),
        .HIPRIO_IDX      (HPI)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .slave_req_o   (sreq),
        .slave_resp_i  (sresp),
        .outstanding_o (outst),
        .err_o         (err)
    );

    function automatic void predict();
        p_valid = 1'b0;
        p_sel   = 0;
        if (m_lock) begin
            p_sel   = m_lidx;
            p_valid = mreq[m_lidx].req;
        end else if (m_fifo.size() < MAXO) begin
            if (mreq[HPI].req) begin
                p_valid = 1'b1;
                p_sel   = HPI;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!p_valid && mreq[(m_rr + k) % N].req) begin
                        p_valid = 1'b1;
                        p_sel   = (m_rr + k) % N;
                    end
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] gvec();
        logic [N-1:0] v;
        for (int m = 0; m < N; m++) v[m] = mresp[m].gnt;
        return v;
    endfunction

    function automatic logic [N-1:0] rvec();
        logic [N-1:0] v;
        for (int m = 0; m < N; m++) v[m] = mresp[m].rvalid;
        return v;
    endfunction

    function automatic obi_req_t mk_req(int m, logic [31:0] addr);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = m[0];
        r.be    = 4'hF;
        r.addr  = addr;
        r.wdata = 32'h1111_1111 * m;
        return r;
    endfunction

    task automatic step();
        bit v;
        int s;
        predict();
        v = p_valid;
        s = p_sel;
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0; m_last_gnt = '0;
        end else begin
            m_last_gnt = '0;
            if (sresp.rvalid) begin
                if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                else m_err = 1'b1;
            end
            if (v && sresp.gnt) begin
                m_fifo.push_back(s);
                m_rr = (s + 1) % N;
                m_lock = 1'b0;
                m_last_gnt[s] = 1'b1;
            end else if (v) begin
                m_lock = 1'b1;
                m_lidx = s;
            end else begin
                m_lock = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        mreq  = '0;
        sresp = '0;
        step();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #4;
        n_cmp++; if (outst !== '0) begin n_fail++; $display("FAIL reset_outst: got %0d expected 0", outst); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (sreq !== '0) begin n_fail++; $display("FAIL reset_sreq: got %h expected 0", sreq); end
        n_cmp++; if (mresp !== '0) begin n_fail++; $display("FAIL reset_mresp: got %h expected 0", mresp); end
        step();
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        mreq[0] = mk_req(0, 32'h1000_0000);
        mreq[1] = mk_req(1, 32'h1100_0000);
        mreq[3] = mk_req(3, 32'h1300_0000);
        for (int k = 0; k <= 6; k++) begin
            if (k == 6) begin
                mreq = '0;
                sresp.gnt = 1'b0;
            end else begin
                sresp.gnt = 1'b1;
            end
            sresp.rvalid = (k > 0);
            sresp.rdata  = (k > 0) ? 32'hA0 + order[k-1] : 32'h0;
            #4;
            if (k < 6) begin
                n_cmp++;
                if (gvec() !== 4'(1 << order[k])) begin
                    n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gvec(), 4'(1 << order[k]));
                end
            end
            if (k > 0) begin
                n_cmp++;
                if (rvec() !== 4'(1 << order[k-1]) || mresp[order[k-1]].rdata !== 32'hA0 + order[k-1]) begin
                    n_fail++; $display("FAIL rr_resp[%0d]: got rvalid %b rdata %h expected rvalid %b rdata %h",
                                       k, rvec(), mresp[order[k-1]].rdata, 4'(1 << order[k-1]), 32'hA0 + order[k-1]);
                end
            end
            step();
        end
        sresp = '0;
        #4;
        n_cmp++; if (outst !== '0) begin n_fail++; $display("FAIL rr_drain: got %0d expected 0", outst); end
        step();
    endtask

    task automatic test_priority_lock();
        do_reset();
        mreq[0] = mk_req(0, 32'h2000_0000);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) mreq[2] = mk_req(2, 32'h3000_0000);
            #4;
            n_cmp++;
            if (sreq.req !== 1'b1 || sreq.addr !== 32'h2000_0000 || gvec() !== '0) begin
                n_fail++; $display("FAIL lock_hold[%0d]: got req %b addr %h gnt %b expected req 1 addr 20000000 gnt 0000",
                                   c, sreq.req, sreq.addr, gvec());
            end
            step();
        end
        sresp.gnt = 1'b1;
        #4;
        n_cmp++; if (gvec() !== 4'b0001) begin n_fail++; $display("FAIL lock_grant: got %b expected 0001", gvec()); end
        step();
        mreq[0] = '0;
        #4;
        n_cmp++;
        if (gvec() !== 4'b0100 || sreq.addr !== 32'h3000_0000) begin
            n_fail++; $display("FAIL prio_grant: got gnt %b addr %h expected gnt 0100 addr 30000000", gvec(), sreq.addr);
        end
        step();
        mreq = '0;
        sresp.gnt = 1'b0;
        sresp.rvalid = 1'b1;
        sresp.rdata = 32'h55;
        #4;
        n_cmp++; if (rvec() !== 4'b0001 || mresp[0].rdata !== 32'h55) begin n_fail++; $display("FAIL lock_resp0: got %b %h expected 0001 55", rvec(), mresp[0].rdata); end
        step();
        sresp.rdata = 32'h66;
        #4;
        n_cmp++; if (rvec() !== 4'b0100 || mresp[2].rdata !== 32'h66) begin n_fail++; $display("FAIL lock_resp2: got %b %h expected 0100 66", rvec(), mresp[2].rdata); end
        step();
        sresp = '0;
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        mreq[0] = mk_req(0, 32'h4000_0000);
        mreq[1] = mk_req(1, 32'h4100_0000);
        sresp.gnt = 1'b1;
        #4;
        n_cmp++; if (gvec() !== 4'b0001) begin n_fail++; $display("FAIL lim_g0: got %b expected 0001", gvec()); end
        step();
        #4;
        n_cmp++; if (gvec() !== 4'b0010) begin n_fail++; $display("FAIL lim_g1: got %b expected 0010", gvec()); end
        step();
        #4;
        n_cmp++;
        if (sreq.req !== 1'b0 || gvec() !== '0 || outst !== CW'(2)) begin
            n_fail++; $display("FAIL lim_full: got req %b gnt %b outst %0d expected req 0 gnt 0000 outst 2", sreq.req, gvec(), outst);
        end
        step();
        sresp.rvalid = 1'b1;
        sresp.rdata = 32'h77;
        #4;
        n_cmp++;
        if (rvec() !== 4'b0001 || sreq.req !== 1'b0 || gvec() !== '0) begin
            n_fail++; $display("FAIL lim_pop: got rvalid %b req %b gnt %b expected rvalid 0001 req 0 gnt 0000", rvec(), sreq.req, gvec());
        end
        step();
        sresp.rvalid = 1'b0;
        #4;
        n_cmp++;
        if (gvec() !== 4'b0001 || outst !== CW'(1)) begin
            n_fail++; $display("FAIL lim_resume: got gnt %b outst %0d expected gnt 0001 outst 1", gvec(), outst);
        end
        step();
        mreq = '0;
        sresp.gnt = 1'b0;
        sresp.rvalid = 1'b1;
        #4;
        n_cmp++; if (rvec() !== 4'b0010) begin n_fail++; $display("FAIL lim_drain1: got %b expected 0010", rvec()); end
        step();
        #4;
        n_cmp++; if (rvec() !== 4'b0001) begin n_fail++; $display("FAIL lim_drain0: got %b expected 0001", rvec()); end
        step();
        sresp = '0;
    endtask

    task automatic test_out_of_context();
        do_reset();
        sresp.rvalid = 1'b1;
        sresp.rdata = 32'hDEAD;
        #4;
        n_cmp++; if (rvec() !== '0) begin n_fail++; $display("FAIL ooc_route: got %b expected 0000", rvec()); end
        step();
        sresp = '0;
        for (int c = 0; c < 3; c++) begin
            #4;
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ooc_err[%0d]: got %b expected 1", c, err); end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mreq[0] = mk_req(0, 32'h5000_0000);
        mreq[1] = mk_req(1, 32'h5100_0000);
        sresp.gnt = 1'b1;
        step();
        step();
        mreq = '0;
        sresp = '0;
        #4;
        n_cmp++; if (outst !== CW'(2)) begin n_fail++; $display("FAIL mid_pre: got %0d expected 2", outst); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #4;
        n_cmp++;
        if (outst !== '0 || sreq !== '0 || mresp !== '0 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_clear: got outst %0d sreq %h mresp %h err %b expected all 0", outst, sreq, mresp, err);
        end
        sresp.rvalid = 1'b1;
        #4;
        n_cmp++; if (rvec() !== '0) begin n_fail++; $display("FAIL mid_stale_route: got %b expected 0000", rvec()); end
        step();
        sresp = '0;
        #4;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %b expected 1", err); end
        mreq[1] = mk_req(1, 32'h6100_0000);
        mreq[3] = mk_req(3, 32'h6300_0000);
        #1;
        n_cmp++; if (sreq.addr !== 32'h6100_0000) begin n_fail++; $display("FAIL mid_rrptr: got %h expected 61000000", sreq.addr); end
        step();
        mreq = '0;
        step();
    endtask

    task automatic test_push_pop();
        do_reset();
        mreq[1] = mk_req(1, 32'h7100_0000);
        sresp.gnt = 1'b1;
        #4;
        n_cmp++; if (gvec() !== 4'b0010) begin n_fail++; $display("FAIL pp_g1: got %b expected 0010", gvec()); end
        step();
        mreq[1] = '0;
        mreq[3] = mk_req(3, 32'h7300_0000);
        sresp.rvalid = 1'b1;
        sresp.rdata = 32'h11;
        #4;
        n_cmp++;
        if (gvec() !== 4'b1000 || rvec() !== 4'b0010 || mresp[1].rdata !== 32'h11 || outst !== CW'(1)) begin
            n_fail++; $display("FAIL pp_same: got gnt %b rvalid %b rdata %h outst %0d expected 1000 0010 11 1",
                               gvec(), rvec(), mresp[1].rdata, outst);
        end
        step();
        mreq = '0;
        sresp.gnt = 1'b0;
        sresp.rdata = 32'h33;
        #4;
        n_cmp++;
        if (outst !== CW'(1) || rvec() !== 4'b1000 || mresp[3].rdata !== 32'h33) begin
            n_fail++; $display("FAIL pp_next: got outst %0d rvalid %b rdata %h expected 1 1000 33", outst, rvec(), mresp[3].rdata);
        end
        step();
        sresp = '0;
        #4;
        n_cmp++; if (outst !== '0) begin n_fail++; $display("FAIL pp_empty: got %0d expected 0", outst); end
        step();
    endtask

    task automatic test_random();
        obi_req_t     exp_req;
        logic [N-1:0] exp_g, exp_r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < N; m++) begin
                if (mreq[m].req && !m_last_gnt[m] && $urandom_range(0, 19) != 0) begin
                    mreq[m] = mreq[m];
                end else if ($urandom_range(0, 4) < 2) begin
                    mreq[m] = mk_req(m, $urandom);
                end else begin
                    mreq[m] = '0;
                end
            end
            sresp.gnt    = ($urandom_range(0, 3) != 0);
            sresp.rvalid = (m_fifo.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            sresp.rdata  = $urandom;
            predict();
            exp_req = p_valid ? mreq[p_sel] : '0;
            exp_g   = (p_valid && sresp.gnt) ? 4'(1 << p_sel) : '0;
            exp_r   = (sresp.rvalid && m_fifo.size() > 0) ? 4'(1 << m_fifo[0]) : '0;
            #4;
            n_cmp++; if (sreq !== exp_req) begin n_fail++; $display("FAIL rnd_sreq[%0d]: got %h expected %h", c, sreq, exp_req); end
            n_cmp++; if (gvec() !== exp_g) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gvec(), exp_g); end
            n_cmp++; if (rvec() !== exp_r) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, rvec(), exp_r); end
            if (exp_r != '0) begin
                n_cmp++;
                if (mresp[m_fifo[0]].rdata !== sresp.rdata) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, mresp[m_fifo[0]].rdata, sresp.rdata);
                end
            end
            n_cmp++; if (outst !== CW'(m_fifo.size())) begin n_fail++; $display("FAIL rnd_outst[%0d]: got %0d expected %0d", c, outst, m_fifo.size()); end
            n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, err, m_err); end
            step();
        end
        mreq  = '0;
        sresp = '0;
    endtask

    initial begin
        rst   = 1'b1;
        mreq  = '0;
        sresp = '0;
        m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0; m_last_gnt = '0;
        #1;
        test_reset();
        test_round_robin();
        test_priority_lock();
        test_outstanding_limit();
        test_out_of_context();
        test_reset_midflight();
        test_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
